// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if: requester, pad and master-engine signals around the I2C bus arbiter
interface i2c_bus_arbiter_if #(parameter int N_REQ = 3);
    logic [N_REQ-1:0]    req;
    logic [7*N_REQ-1:0]  req_addr;
    logic [N_REQ-1:0]    req_rnw;
    logic [16*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rsp_valid;
    logic                rsp_err;
    logic [15:0]         rsp_rdata;
    logic                scl_in;
    logic                sda_in;
    logic                mst_start;
    logic [6:0]          mst_addr;
    logic                mst_rnw;
    logic [15:0]         mst_wdata;
    logic                mst_done;
    logic                mst_nack;
    logic [15:0]         mst_rdata;
    logic                mst_abort;
    modport master (
        input  req, req_addr, req_rnw, req_wdata, scl_in, sda_in, mst_done, mst_nack, mst_rdata,
        output gnt, rsp_valid, rsp_err, rsp_rdata, mst_start, mst_addr, mst_rnw, mst_wdata, mst_abort
    );
    modport slave (
        output req, req_addr, req_rnw, req_wdata, scl_in, sda_in, mst_done, mst_nack, mst_rdata,
        input  gnt, rsp_valid, rsp_err, rsp_rdata, mst_start, mst_addr, mst_rnw, mst_wdata, mst_abort
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one I2C master engine among N_REQ sensor pollers
module i2c_bus_arbiter #(
    parameter int N_REQ    = 3,
    parameter int BUS_FREE = 8,
    parameter int TIMEOUT  = 50000,
    parameter int TMR_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    i2c_bus_arbiter_if.master bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int FW = $clog2(BUS_FREE + 1);
    typedef enum logic [2:0] {IDLE, WAIT_FREE, START, BUSY, RESP} state_t;
    state_t        state;
    logic [IW-1:0] ptr, idx, sel;
    logic [FW-1:0] free_cnt;
    logic [TMR_W-1:0] timer;
    logic          found, bus_idle, time_up;
    assign bus_idle = bus.scl_in & bus.sda_in;
    assign time_up  = timer == TMR_W'(TIMEOUT - 1);
    // abort must see mst_done in the same cycle so a coincident done can suppress it
    assign bus.mst_abort = (state == BUSY) && time_up && !bus.mst_done;
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (bus.req[j]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            idx           <= '0;
            free_cnt      <= '0;
            timer         <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.mst_start <= 1'b0;
            bus.mst_addr  <= '0;
            bus.mst_rnw   <= 1'b0;
            bus.mst_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    idx           <= sel;
                    bus.gnt       <= N_REQ'(1) << sel;
                    bus.mst_addr  <= bus.req_addr[7*sel +: 7];
                    bus.mst_rnw   <= bus.req_rnw[sel];
                    bus.mst_wdata <= bus.req_wdata[16*sel +: 16];
                    free_cnt      <= '0;
                    state         <= WAIT_FREE;
                end
                WAIT_FREE: if (!bus_idle) begin
                    free_cnt <= '0;
                end else if (free_cnt == FW'(BUS_FREE - 1)) begin
                    free_cnt      <= '0;
                    bus.mst_start <= 1'b1;
                    state         <= START;
                end else begin
                    free_cnt <= free_cnt + 1'b1;
                end
                START: begin
                    bus.mst_start <= 1'b0;
                    timer         <= '0;
                    state         <= BUSY;
                end
                BUSY: if (bus.mst_done || time_up) begin
                    bus.rsp_err   <= bus.mst_done ? bus.mst_nack : 1'b1;
                    bus.rsp_rdata <= bus.mst_done ? bus.mst_rdata : 16'h0000;
                    bus.rsp_valid <= N_REQ'(1) << idx;
                    state         <= RESP;
                end else begin
                    timer <= timer + 1'b1;
                end
                RESP: begin
                    bus.rsp_valid <= '0;
                    bus.gnt       <= '0;
                    ptr           <= (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: vector table of transactions with a response scoreboard, plus reset corner cases
module tb_i2c_bus_arbiter;
    localparam int N  = 3;
    localparam int BF = 8;
    localparam int TO = 100;
    typedef struct {
        logic [2:0]  req;
        logic [6:0]  addr;
        logic        rnw;
        logic [15:0] wdata;
        int          dly;
        int          glitch;
        logic        nack;
        logic [15:0] rdata;
        logic [2:0]  gnt;
        int          start;
        logic        err;
        logic [15:0] rsp;
    } vec_t;
    typedef struct packed {
        logic [2:0]  gnt;
        logic        err;
        logic [15:0] rdata;
    } rsp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;
    rsp_t sbq[$];
    rsp_t exp_rsp;
    vec_t vt[10];
    always #5 clk = ~clk;
    i2c_bus_arbiter_if #(.N_REQ(N)) bus ();
    i2c_bus_arbiter #(.N_REQ(N), .BUS_FREE(BF), .TIMEOUT(TO), .TMR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if ($countones(bus.gnt) > 1 || $countones(bus.rsp_valid) > 1) begin
            n_fail++;
            $display("FAIL onehot: gnt %b rsp_valid %b, expected at most one bit each", bus.gnt, bus.rsp_valid);
        end
        if (bus.rsp_valid != '0) begin
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid %b, expected none", bus.rsp_valid);
            end else begin
                exp_rsp = sbq.pop_front();
                chk("rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 32'(exp_rsp));
            end
        end
    end
    task automatic txn(input vec_t v);
        int s;
        int gi;
        gi = (v.gnt == 3'b001) ? 0 : (v.gnt == 3'b010) ? 1 : 2;
        bus.req = v.req;
        bus.req_rnw = {N{v.rnw}};
        for (int i = 0; i < N; i++) begin
            bus.req_addr[7*i +: 7]   = v.addr + 7'(i);
            bus.req_wdata[16*i +: 16] = v.wdata + 16'(i);
        end
        @(negedge clk);
        chk("gnt", 32'(bus.gnt), 32'(v.gnt));
        s = 0;
        for (int c = 2; c <= 60 && s == 0; c++) begin
            @(negedge clk);
            bus.sda_in = (c != v.glitch);
            if (bus.mst_start) s = c;
        end
        chk("start_cycle", 32'(s), 32'(v.start));
        chk("mst_addr", 32'(bus.mst_addr), 32'(v.addr + 7'(gi)));
        chk("mst_rnw", 32'(bus.mst_rnw), 32'(v.rnw));
        chk("mst_wdata", 32'(bus.mst_wdata), 32'(v.wdata + 16'(gi)));
        sbq.push_back('{gnt: v.gnt, err: v.err, rdata: v.rsp});
        bus.req = '0;
        bus.req_addr = ~bus.req_addr;
        bus.req_wdata = ~bus.req_wdata;
        bus.req_rnw = ~bus.req_rnw;
        if (v.dly > 0) begin
            repeat (v.dly) @(negedge clk);
            bus.mst_done = 1'b1;
            bus.mst_nack = v.nack;
            bus.mst_rdata = v.rdata;
            #1 chk("no_abort", 32'(bus.mst_abort), 32'(0));
            @(negedge clk);
            bus.mst_done = 1'b0;
        end else begin
            repeat (TO - 1) @(negedge clk);
            chk("abort_early", 32'(bus.mst_abort), 32'(0));
            @(negedge clk);
            chk("abort", 32'(bus.mst_abort), 32'(1));
            @(negedge clk);
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(v.gnt));
        @(negedge clk);
        chk("gnt_clr", 32'(bus.gnt), 32'(0));
        chk("addr_hold", 32'(bus.mst_addr), 32'(v.addr + 7'(gi)));
    endtask
    initial begin
        vt[0] = '{3'b001, 7'h48, 1'b1, 16'h0000, 40, 0, 1'b0, 16'h1A2B, 3'b001, 9, 1'b0, 16'h1A2B};
        vt[1] = '{3'b111, 7'h10, 1'b1, 16'h1234, 5, 0, 1'b0, 16'h1111, 3'b010, 9, 1'b0, 16'h1111};
        vt[2] = '{3'b111, 7'h20, 1'b1, 16'h0000, 3, 0, 1'b0, 16'h2222, 3'b100, 9, 1'b0, 16'h2222};
        vt[3] = '{3'b111, 7'h30, 1'b1, 16'h0000, 1, 0, 1'b0, 16'h3333, 3'b001, 9, 1'b0, 16'h3333};
        vt[4] = '{3'b001, 7'h50, 1'b0, 16'hBEEF, 7, 0, 1'b1, 16'h5555, 3'b001, 9, 1'b1, 16'h5555};
        vt[5] = '{3'b100, 7'h60, 1'b1, 16'h0000, -1, 0, 1'b0, 16'h9999, 3'b100, 9, 1'b1, 16'h0000};
        vt[6] = '{3'b110, 7'h70, 1'b1, 16'h0000, TO, 0, 1'b0, 16'hABCD, 3'b010, 9, 1'b0, 16'hABCD};
        vt[7] = '{3'b011, 7'h08, 1'b1, 16'h0000, 2, 0, 1'b1, 16'h0F0F, 3'b001, 9, 1'b1, 16'h0F0F};
        vt[8] = '{3'b010, 7'h22, 1'b0, 16'h7777, 4, 6, 1'b0, 16'h4444, 3'b010, 15, 1'b0, 16'h4444};
        vt[9] = '{3'b110, 7'h40, 1'b1, 16'h0000, 6, 0, 1'b0, 16'h6666, 3'b010, 9, 1'b0, 16'h6666};
        bus.req = '0;
        bus.req_addr = '0;
        bus.req_rnw = '0;
        bus.req_wdata = '0;
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        bus.mst_done = 1'b0;
        bus.mst_nack = 1'b0;
        bus.mst_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'({bus.gnt, bus.rsp_valid, bus.rsp_err, bus.mst_start, bus.mst_rnw, bus.mst_abort}), 32'(0));
        chk("reset_data", 32'({bus.mst_addr, bus.mst_wdata}), 32'(0));
        chk("reset_rdata", 32'(bus.rsp_rdata), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        bus.mst_done = 1'b1;
        @(negedge clk);
        bus.mst_done = 1'b0;
        @(negedge clk);
        chk("idle_done_ignored", 32'({bus.gnt, bus.rsp_valid}), 32'(0));
        for (int i = 0; i < 9; i++) txn(vt[i]);
        bus.req = 3'b010;
        bus.req_addr[13:7] = 7'h33;
        @(negedge clk);
        chk("rst_seq_gnt", 32'(bus.gnt), 32'(3'b010));
        for (int c = 0; c < 40 && !bus.mst_start; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl", 32'({bus.gnt, bus.rsp_valid, bus.rsp_err, bus.mst_start, bus.mst_rnw, bus.mst_abort}), 32'(0));
        chk("midrst_data", 32'({bus.mst_addr, bus.mst_wdata}), 32'(0));
        chk("midrst_rdata", 32'(bus.rsp_rdata), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        txn(vt[9]);
        repeat (3) @(negedge clk);
        chk("sbq_empty", 32'(sbq.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Shares the chip's single I2C master engine among N_REQ sensor-polling requesters (solar, greenhouse, geothermal). It arbitrates round-robin, waits for the SCL/SDA pad inputs to show a free bus, and issues one transaction to the master engine. It then returns read data and NACK/timeout status to the granted requester. It sits between the sensor pollers in `main` and the I2C master that drives `sda_out`/`scl_out`.

## Interface
Parameters:
- N_REQ, 3, number of requesters; index 0 = solar, 1 = greenhouse, 2 = geothermal.
- BUS_FREE, 8, consecutive cycles with scl_in=sda_in=1 required before a start.
- TIMEOUT, 50000, cycles allowed from mst_start to mst_done before abort.
- TMR_W, 16, timer width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req  in  N_REQ  per-requester request level.
- req_addr  in  7*N_REQ  7-bit device address; slice i = bits [7i+6:7i].
- req_rnw  in  N_REQ  1 = read, 0 = write.
- req_wdata  in  16*N_REQ  write payload; slice i = bits [16i+15:16i].
- gnt  out  N_REQ  one-hot grant, held for the whole transaction.
- rsp_valid  out  N_REQ  one-cycle response strobe to the granted requester.
- rsp_err  out  1  NACK or timeout; valid while any rsp_valid bit is high.
- rsp_rdata  out  16  read data; valid while any rsp_valid bit is high.
- scl_in, sda_in  in  1 each  bus state from the bidirectional pads.
- mst_start  out  1  one-cycle transaction start.
- mst_addr  out  7  latched address.
- mst_rnw  out  1  latched direction.
- mst_wdata  out  16  latched write data.
- mst_done  in  1  one-cycle completion pulse from the master.
- mst_nack  in  1  NACK status; valid with mst_done.
- mst_rdata  in  16  read data; valid with mst_done.
- mst_abort  out  1  one-cycle abort pulse; the master releases the bus.

## Operation
- State machine: IDLE, WAIT_FREE, START, BUSY, RESP.
- IDLE:
  - If any req bit is high, select the first requester at or after ptr, searching upward and wrapping modulo N_REQ.
  - Latch the selected index and its addr, rnw and wdata into the mst_* registers.
  - Set that gnt bit, then go to WAIT_FREE.
- WAIT_FREE:
  - free_cnt increments on each cycle with scl_in&sda_in=1 and clears to 0 on any other cycle.
  - When free_cnt = BUS_FREE-1 and the bus is still idle, go to START.
- START: mst_start=1 for this cycle only; clear the timer; go to BUSY.
- BUSY:
  - On mst_done: latch rsp_err=mst_nack and rsp_rdata=mst_rdata; go to RESP.
  - Otherwise, when the timer reaches TIMEOUT-1: pulse mst_abort, set rsp_err=1 and rsp_rdata=0; go to RESP.
  - If mst_done and the timeout fall in the same cycle, mst_done wins and mst_abort is not asserted.
- RESP:
  - Assert rsp_valid[idx] for one cycle.
  - Set ptr = (idx+1) mod N_REQ.
  - Clear gnt in the next cycle; go to IDLE.
- Payload is sampled only at grant. Changes to req, addr or wdata after grant are ignored. If req drops mid-transaction, the transaction still completes and the response is still issued.
- mst_done is ignored in IDLE, WAIT_FREE, START and RESP.
- mst_addr, mst_rnw and mst_wdata hold their values until the next grant.
- Reset (asynchronous, any state):
  - State returns to IDLE; ptr=0.
  - free_cnt and timer = 0.
  - All outputs = 0, including gnt, rsp_*, mst_*.
  - Any in-flight transaction is dropped without a response.

## Timing
- Cycle 0: req is seen in IDLE. Cycle 1: gnt is high.
- With the bus idle throughout, mst_start is high in cycle 1+BUS_FREE.
- A bus-busy cycle during WAIT_FREE restarts the BUS_FREE count.
- mst_done in cycle d gives rsp_valid in cycle d+1; gnt is low in cycle d+2.
- mst_start in cycle s with no done gives mst_abort in cycle s+TIMEOUT and rsp_valid (err=1) in cycle s+TIMEOUT+1.
- The earliest next grant falls 2 cycles after rsp_valid.
- At most one transaction is outstanding; gnt and rsp_valid are always one-hot or zero.

## Test plan
- Single read:
  - Stimulus: req=001, addr0=0x48, rnw=1, bus idle, BUS_FREE=8; mst_done+rdata=0x1A2B, nack=0 at s+40.
  - Required: gnt=001 at cycle 1; mst_start at cycle 9 with addr 0x48; rsp_valid=001, rdata=0x1A2B, err=0 at s+41.
- Round-robin:
  - Stimulus: req=111 held; each transaction completes.
  - Required: grants in order 001, 010, 100, 001; never two bits at once.
- Bus-free guard:
  - Stimulus: sda_in=0 pulse at WAIT_FREE count 5.
  - Required: count restarts; mst_start comes 8 idle cycles after the pulse.
- Timeout:
  - Stimulus: TIMEOUT=100, no mst_done.
  - Required: mst_abort at s+100; rsp_err=1, rdata=0x0000 at s+101; a done at s+100 instead gives err=mst_nack and no abort.
- NACK write:
  - Stimulus: rnw=0, wdata=0xBEEF; done with nack=1.
  - Required: mst_wdata=0xBEEF; rsp_err=1.
- Reset mid-transaction:
  - Stimulus: rst low in BUSY with gnt=010.
  - Required: all outputs 0 immediately; after release, req=110 grants 010 first (ptr=0 searches up from 0, so 010 precedes 100).
